// File: rtl/huffman_stream_scheduler.sv
// Round-robin scheduler sharing one huffman_decoder across NUM_CH channels.
// Optional perf counters (perf_zero_cnt, perf_bit_cnt) when HUFF_SCHED_PERF_EN is defined.
module huffman_stream_scheduler #(
  parameter int NUM_CH = 4,
  parameter int WORD_W = 32,
  parameter int LEN_W  = 16,
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int BCW   = $clog2(WORD_W + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  output logic [NUM_CH-1:0]        ch_grant,
  input  logic [NUM_CH*WORD_W-1:0] ch_word,
  input  logic [NUM_CH-1:0]        ch_word_valid,
  output logic [NUM_CH-1:0]        ch_word_ready,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     dec_bit,
  output logic                     dec_bit_valid,
  input  logic [7:0]               dec_data,
  input  logic                     dec_data_valid,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  output logic [CW-1:0]            out_ch,
  output logic                     out_last
`ifdef HUFF_SCHED_PERF_EN
  ,
  output logic [LEN_W-1:0]         perf_zero_cnt,
  output logic [31:0]              perf_bit_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_SHIFT, S_DRAIN, S_DONE} state_t;

  state_t              state_reg;
  logic [CW-1:0]       rr_reg;
  logic [CW-1:0]       g_reg;
  logic [LEN_W-1:0]    len_reg;
  logic [LEN_W-1:0]    issued_reg;
  logic [LEN_W-1:0]    recv_reg;
  logic [WORD_W-1:0]   sreg_reg;
  logic [BCW-1:0]      bit_cnt_reg;
  logic [3:0]          cw_rem_reg;
  logic                started_reg;

  logic [LEN_W-1:0]    len_arr  [NUM_CH];
  logic [WORD_W-1:0]   word_arr [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign len_arr[gi]  = ch_len[gi*LEN_W +: LEN_W];
      assign word_arr[gi] = ch_word[gi*WORD_W +: WORD_W];
    end
  endgenerate

  // First requester strictly after rr_reg, wrapping; the smallest offset wins.
  logic          arb_found;
  logic [CW-1:0] arb_idx;
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (ch_req[(int'(rr_reg) + i) % NUM_CH]) begin
        arb_found = 1'b1;
        arb_idx   = CW'((int'(rr_reg) + i) % NUM_CH);
      end
    end
  end

  logic [NUM_CH-1:0] grant_mask, arb_mask;
  assign grant_mask    = NUM_CH'(1) << g_reg;
  assign arb_mask      = NUM_CH'(1) << arb_idx;
  assign ch_word_ready = (state_reg == S_LOAD) ? grant_mask : '0;

  // Shadow parser mirrors the decoder's codeword framing one bit at a time.
  logic             s_bit, cw_end;
  logic [3:0]       cw_rem_next;
  logic [LEN_W-1:0] issued_next;
  assign s_bit = sreg_reg[WORD_W-1];
  always_comb begin
    cw_end      = 1'b0;
    cw_rem_next = cw_rem_reg;
    if (cw_rem_reg == 4'd0) begin
      cw_end      = ~s_bit;
      cw_rem_next = s_bit ? 4'd8 : 4'd0;
    end else begin
      cw_end      = (cw_rem_reg == 4'd1);
      cw_rem_next = cw_rem_reg - 4'd1;
    end
  end
  assign issued_next = issued_reg + {{(LEN_W-1){1'b0}}, cw_end};

  logic accept_out;
  assign accept_out = dec_data_valid &&
                      ((state_reg == S_SHIFT) || (state_reg == S_DRAIN) ||
                       ((state_reg == S_LOAD) && started_reg));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      rr_reg        <= CW'(NUM_CH - 1);
      g_reg         <= '0;
      len_reg       <= '0;
      issued_reg    <= '0;
      recv_reg      <= '0;
      sreg_reg      <= '0;
      bit_cnt_reg   <= '0;
      cw_rem_reg    <= '0;
      started_reg   <= 1'b0;
      ch_grant      <= '0;
      ch_done       <= '0;
      dec_bit       <= 1'b0;
      dec_bit_valid <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_ch        <= '0;
      out_last      <= 1'b0;
`ifdef HUFF_SCHED_PERF_EN
      perf_zero_cnt <= '0;
      perf_bit_cnt  <= '0;
`endif
    end else begin
      ch_done   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (accept_out) begin
        out_valid <= 1'b1;
        out_data  <= dec_data;
        out_ch    <= g_reg;
        out_last  <= (recv_reg == len_reg - LEN_W'(1));
        recv_reg  <= recv_reg + LEN_W'(1);
      end
      case (state_reg)
        S_IDLE: begin
          dec_bit_valid <= 1'b0;
          if (|ch_req) state_reg <= S_ARB;
        end
        S_ARB: begin
          if (arb_found) begin
            g_reg       <= arb_idx;
            ch_grant    <= arb_mask;
            len_reg     <= len_arr[arb_idx];
            issued_reg  <= '0;
            recv_reg    <= '0;
            cw_rem_reg  <= '0;
            started_reg <= 1'b0;
`ifdef HUFF_SCHED_PERF_EN
            perf_zero_cnt <= '0;
            perf_bit_cnt  <= '0;
`endif
            if (len_arr[arb_idx] == '0) begin
              ch_done   <= arb_mask;
              state_reg <= S_DONE;
            end else begin
              state_reg <= S_LOAD;
            end
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_LOAD: begin
          dec_bit_valid <= 1'b0;
          if (ch_word_valid[g_reg]) begin
            sreg_reg    <= word_arr[g_reg];
            bit_cnt_reg <= BCW'(WORD_W);
            state_reg   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          dec_bit       <= s_bit;
          dec_bit_valid <= 1'b1;
          started_reg   <= 1'b1;
          sreg_reg      <= sreg_reg << 1;
          bit_cnt_reg   <= bit_cnt_reg - BCW'(1);
          cw_rem_reg    <= cw_rem_next;
          issued_reg    <= issued_next;
`ifdef HUFF_SCHED_PERF_EN
          perf_bit_cnt  <= perf_bit_cnt + 32'd1;
          if ((cw_rem_reg == 4'd0) && !s_bit) perf_zero_cnt <= perf_zero_cnt + LEN_W'(1);
`endif
          // Burst end wins over word end: leftover word bits are dropped.
          if (issued_next == len_reg) state_reg <= S_DRAIN;
          else if (bit_cnt_reg == BCW'(1)) state_reg <= S_LOAD;
        end
        S_DRAIN: begin
          dec_bit_valid <= 1'b0;
          if (recv_reg == len_reg) begin
            ch_done   <= grant_mask;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          ch_grant  <= '0;
          rr_reg    <= g_reg;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_stream_scheduler.sv
// Directed bench for huffman_stream_scheduler with a behavioural decoder and word source.
module tb_huffman_stream_scheduler;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   ch_req = '0;
  logic [63:0]  ch_len = '0;
  logic [3:0]   ch_grant;
  logic [127:0] ch_word = '0;
  logic [3:0]   ch_word_valid = '0;
  logic [3:0]   ch_word_ready;
  logic [3:0]   ch_done;
  logic         dec_bit, dec_bit_valid;
  logic [7:0]   dec_data = '0;
  logic         dec_data_valid = 1'b0;
  logic [7:0]   out_data;
  logic         out_valid;
  logic [1:0]   out_ch;
  logic         out_last;
`ifdef HUFF_SCHED_PERF_EN
  logic [15:0]  perf_zero_cnt;
  logic [31:0]  perf_bit_cnt;
`endif

  huffman_stream_scheduler #(.NUM_CH(4), .WORD_W(32), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_len(ch_len), .ch_grant(ch_grant),
    .ch_word(ch_word), .ch_word_valid(ch_word_valid), .ch_word_ready(ch_word_ready),
    .ch_done(ch_done), .dec_bit(dec_bit), .dec_bit_valid(dec_bit_valid),
    .dec_data(dec_data), .dec_data_valid(dec_data_valid), .out_data(out_data),
    .out_valid(out_valid), .out_ch(out_ch), .out_last(out_last)
`ifdef HUFF_SCHED_PERF_EN
    , .perf_zero_cnt(perf_zero_cnt), .perf_bit_cnt(perf_bit_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural decoder: '0' -> 0x00, '1'+8 bits -> byte, output registered.
  logic [3:0] dm_rem = '0;
  logic [7:0] dm_sh = '0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dm_rem <= '0;
      dec_data_valid <= 1'b0;
      dec_data <= '0;
    end else begin
      dec_data_valid <= 1'b0;
      if (dec_bit_valid) begin
        if (dm_rem == 4'd0) begin
          if (dec_bit) dm_rem <= 4'd8;
          else begin dec_data <= 8'h00; dec_data_valid <= 1'b1; end
        end else begin
          dm_sh  <= {dm_sh[6:0], dec_bit};
          dm_rem <= dm_rem - 4'd1;
          if (dm_rem == 4'd1) begin dec_data <= {dm_sh[6:0], dec_bit}; dec_data_valid <= 1'b1; end
        end
      end
    end
  end

  // Word source: table filled by the stimulus; gap counts cycles that LOAD waits.
  logic [31:0] wtab [32];
  int wcount = 0, word_gap = 0, words_taken = 0, last_taken = 0, gap_cnt = 0;
  always @(posedge clk) begin
    if (!reset && |(ch_word_valid & ch_word_ready)) words_taken++;
  end
  always @(negedge clk) begin
    if (words_taken != last_taken) begin
      last_taken = words_taken;
      gap_cnt = word_gap;
    end else if (gap_cnt > 0 && |ch_word_ready) begin
      gap_cnt--;
    end
    if (words_taken < wcount && gap_cnt == 0) begin
      ch_word = {4{wtab[words_taken]}};
      ch_word_valid = 4'hF;
    end else begin
      ch_word_valid = 4'h0;
    end
  end

  logic [10:0] out_q[$];
  int bits_sent = 0, ready_cyc = 0, dbv_in_load = 0;
  always @(negedge clk) begin
    if (out_valid) out_q.push_back({out_last, out_ch, out_data});
    if (dec_bit_valid) bits_sent++;
    if (|ch_word_ready) ready_cyc++;
    if (|ch_word_ready && dec_bit_valid) dbv_in_load++;
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int ch, output int cyc);
    ch = -1;
    cyc = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      cyc++;
      if (|ch_done) begin
        for (int c = 0; c < 4; c++) if (ch_done[c]) ch = c;
        ch_req[ch] = 1'b0;
        return;
      end
    end
    check("done_timeout", 64'd0, 64'd1);
  endtask

  int ch, cyc, ob, bs, wt, rc, dl;
  logic found;

  initial begin
    #12;
    check("reset_outputs", {ch_grant, ch_done, ch_word_ready, dec_bit, dec_bit_valid,
                            out_data, out_valid, out_ch, out_last}, 64'd0);
    @(negedge clk); reset = 1'b0; @(negedge clk);

    // Test 1: ch0 len=3, codes 0 / 1+A5 / 0 in one word
    wtab[wcount] = 32'h6940_0000; wcount++;
    ch_len[15:0] = 16'd3;
    ob = out_q.size(); bs = bits_sent; wt = words_taken;
    ch_req[0] = 1'b1;
    wait_done(ch, cyc);
    check("t1_done_ch", ch, 0);
    @(negedge clk);
    check("t1_done_pulse", ch_done, 4'h0);
    repeat (4) @(negedge clk);
    check("t1_nout", out_q.size() - ob, 3);
    check("t1_bytes", {out_q[ob], out_q[ob+1], out_q[ob+2]}, {11'h000, 11'h0A5, 11'h400});
    check("t1_bits", bits_sent - bs, 11);
    check("t1_words", words_taken - wt, 1);
`ifdef HUFF_SCHED_PERF_EN
    check("t6_perf_zero", perf_zero_cnt, 2);
    check("t6_perf_bits", perf_bit_cnt, 11);
`endif

    // Test 2: round-robin ordering from reset
    @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin wtab[wcount] = 32'h0; wcount++; end
    ch_len = {16'd1, 16'd1, 16'd1, 16'd0};
    ob = out_q.size();
    ch_req = 4'b0110;
    wait_done(ch, cyc);
    check("t2_first", ch, 1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (ch_grant == 4'b0100) found = 1'b1;
    end
    check("t2_grant_ch2", ch_grant, 4'b0100);
    ch_req[3] = 1'b1;
    @(negedge clk); ch_req[1] = 1'b1;
    wait_done(ch, cyc); check("t2_second", ch, 2);
    wait_done(ch, cyc); check("t2_third", ch, 3);
    wait_done(ch, cyc); check("t2_fourth", ch, 1);
    repeat (4) @(negedge clk);
    check("t2_outs", {out_q[ob], out_q[ob+1], out_q[ob+2], out_q[ob+3]},
          {11'h500, 11'h600, 11'h700, 11'h500});

    // Test 3: codeword spans two words with a source gap
    word_gap = 6;
    wtab[wcount] = 32'hFFFF_FFFF; wcount++;
    wtab[wcount] = 32'hF000_0000; wcount++;
    ch_len[15:0] = 16'd4;
    ob = out_q.size(); bs = bits_sent; wt = words_taken; dl = dbv_in_load;
    ch_req[0] = 1'b1;
    wait_done(ch, cyc);
    check("t3_done_ch", ch, 0);
    repeat (4) @(negedge clk);
    word_gap = 0;
    check("t3_nout", out_q.size() - ob, 4);
    check("t3_bytes", {out_q[ob], out_q[ob+1], out_q[ob+2], out_q[ob+3]},
          {11'h0FF, 11'h0FF, 11'h0FF, 11'h4FF});
    check("t3_bits", bits_sent - bs, 36);
    check("t3_words", words_taken - wt, 2);
    check("t3_dbv_in_gap", dbv_in_load - dl, 1);

    // Test 4: zero-length burst
    ch_len[47:32] = 16'd0;
    rc = ready_cyc; bs = bits_sent;
    ch_req[2] = 1'b1;
    wait_done(ch, cyc);
    check("t4_done_ch", ch, 2);
    check("t4_latency_ok", (cyc <= 3), 1);
    repeat (3) @(negedge clk);
    check("t4_no_ready", ready_cyc - rc, 0);
    check("t4_no_bits", bits_sent - bs, 0);

    // Test 5: reset during SHIFT, then a clean burst
    ch_len[15:0] = 16'd1;
    wtab[wcount] = 32'hFFFF_FFFF; wcount++;
    ch_req[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (dec_bit_valid) found = 1'b1;
    end
    check("t5_shift_seen", found, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("t5_reset_outputs", {ch_grant, ch_done, ch_word_ready, dec_bit, dec_bit_valid,
                               out_data, out_valid, out_ch, out_last}, 64'd0);
    ch_req = 4'h0;
    @(negedge clk); reset = 1'b0; @(negedge clk);
    wtab[wcount] = 32'h0; wcount++;
    ob = out_q.size();
    ch_req[0] = 1'b1;
    wait_done(ch, cyc);
    check("t5_done_ch", ch, 0);
    repeat (4) @(negedge clk);
    check("t5_nout", out_q.size() - ob, 1);
    check("t5_byte", out_q[ob], 11'h400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
